// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI initiator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        XFER  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } spi_state_e;

    localparam int SPI_DATA_W_DEF = 8;

    // Mode 0: SCLK idles low, data sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_master_if.sv
// Local-side handshake plus SPI pins of the initiator, grouped as one bundle.
interface spi_master_if #(
    parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              done;
    logic              busy;
    logic              SS;
    logic              SCLK;
    logic              MOSI;
    logic              MISO;
    logic              is_transmitting;
    logic              is_receiving;

    modport master (
        input  start, tx_data, MISO,
        output rx_data, done, busy, SS, SCLK, MOSI, is_transmitting, is_receiving
    );

    modport slave (
        output start, tx_data, MISO,
        input  rx_data, done, busy, SS, SCLK, MOSI, is_transmitting, is_receiving
    );
endinterface

// File: rtl/spi_clk_div.sv
// Free-running divider: one tick every CLK_DIV enabled cycles, restarts when disabled.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int               CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count 0..CLK_DIV-1 while enabled; hold at zero otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/spi_master.sv
// Mode-0 MSB-first SPI initiator; every pin and status output comes from a flop.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W_DEF,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_master_if.master  bus
);
    localparam int               BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_e        state_q, state_d;
    // Bits still to be sent after the one currently on MOSI.
    logic [DATA_W-2:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              ss_q, ss_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              act_q, act_d;
    logic              tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != IDLE),
        .tick  (tick)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        bit_cnt_d  = bit_cnt_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SETUP;
                    mosi_d     = bus.tx_data[DATA_W-1];
                    tx_shift_d = bus.tx_data[DATA_W-2:0];
                    rx_shift_d = '0;
                    bit_cnt_d  = '0;
                    ss_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d    = XFER;
                    sclk_d     = ~SPI_CPOL;
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.MISO};
                end
            end
            XFER: begin
                if (tick) begin
                    if (sclk_q == SPI_CPOL) begin
                        sclk_d     = ~SPI_CPOL;
                        rx_shift_d = {rx_shift_q[DATA_W-2:0], bus.MISO};
                    end else begin
                        sclk_d = SPI_CPOL;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = HOLD;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                            mosi_d     = tx_shift_q[DATA_W-2];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = GAP;
                    ss_d      = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_shift_q;
                    done_d    = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        act_d = ~ss_d;
    end

    // State, shift and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            bit_cnt_q  <= '0;
            ss_q       <= 1'b1;
            sclk_q     <= SPI_CPOL;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            bit_cnt_q  <= bit_cnt_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            act_q      <= act_d;
        end
    end

    assign bus.rx_data         = rx_data_q;
    assign bus.done            = done_q;
    assign bus.busy            = busy_q;
    assign bus.SS              = ss_q;
    assign bus.SCLK            = sclk_q;
    assign bus.MOSI            = mosi_q;
    assign bus.is_transmitting = act_q;
    assign bus.is_receiving    = act_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: loopback, tied MISO, slave model, abort and streaming.
module tb_spi_master;
    import spi_pkg::*;

    localparam int DW       = 8;
    localparam int CD       = 4;
    localparam int DONE_CYC = 1 + (2 * DW + 1) * CD;
    localparam int BUSY_END = (2 * DW + 2) * CD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_master_if #(.DATA_W(DW)) bus ();

    spi_master #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_total = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_exp;

    // MISO source: 0 loopback, 1 tied low, 2 tied high, 3 slave model
    int miso_mode = 0;
    logic [DW-1:0] sl_preload, sl_tx, sl_rx, sl_leds;

    always_comb begin
        case (miso_mode)
            0:       bus.MISO = bus.MOSI;
            1:       bus.MISO = 1'b0;
            2:       bus.MISO = 1'b1;
            default: bus.MISO = sl_tx[DW-1];
        endcase
    end

    // Behavioural mode-0 slave
    always @(negedge bus.SS) begin
        sl_tx = sl_preload;
        sl_rx = '0;
    end
    always @(posedge bus.SCLK) if (bus.SS === 1'b0) sl_rx = {sl_rx[DW-2:0], bus.MOSI};
    always @(negedge bus.SCLK) if (bus.SS === 1'b0) sl_tx = {sl_tx[DW-2:0], 1'b0};
    always @(posedge bus.SS) sl_leds = sl_rx;

    // Monitor: status flag consistency and scoreboard pop on done
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.is_transmitting !== ~bus.SS || bus.is_receiving !== ~bus.SS) begin
                errors++;
                $display("FAIL act_flags: is_transmitting=%b is_receiving=%b, required both %b", bus.is_transmitting, bus.is_receiving, ~bus.SS);
            end
        end
        if (bus.done === 1'b1) begin
            done_total++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done pulse with rx_data=%h, no frame expected", bus.rx_data);
            end else begin
                sb_exp = sb.pop_front();
                if (bus.rx_data !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_rx_data: got %h, required %h", bus.rx_data, sb_exp);
                end
            end
        end
    end

    // Per-frame observations
    logic          fr_ss1, fr_mosi1, prev_sclk;
    logic [DW-1:0] fr_mosi;
    int            fr_rises, fr_done_n, fr_done_cyc, fr_busy_lo, fr_busy_hi, fr_busy_n;
    logic          fr_rst_ss, fr_rst_sclk, fr_rst_mosi, fr_rst_busy;
    logic [DW-1:0] fr_rst_rx;

    task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] exp_rx, input int mode,
                             input int extra_cyc, input int rst_cyc, input bit expect_done);
        miso_mode = mode;
        fr_rises = 0; fr_done_n = 0; fr_done_cyc = 0;
        fr_busy_lo = 0; fr_busy_hi = 0; fr_busy_n = 0;
        fr_mosi = '0; prev_sclk = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = tx;
        if (expect_done) sb.push_back(exp_rx);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start   = 1'b0;
                bus.tx_data = ~tx;
                fr_ss1      = bus.SS;
                fr_mosi1    = bus.MOSI;
            end
            if (extra_cyc != 0 && c == extra_cyc) bus.start = 1'b1;
            if (extra_cyc != 0 && c == extra_cyc + 1) bus.start = 1'b0;
            if (bus.busy === 1'b1) begin
                if (fr_busy_lo == 0) fr_busy_lo = c;
                fr_busy_hi = c;
                fr_busy_n++;
            end
            if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) begin
                fr_rises++;
                fr_mosi = {fr_mosi[DW-2:0], bus.MOSI};
            end
            prev_sclk = bus.SCLK;
            if (bus.done === 1'b1) begin
                fr_done_n++;
                if (fr_done_cyc == 0) fr_done_cyc = c;
            end
            if (rst_cyc != 0 && c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                fr_rst_ss   = bus.SS;
                fr_rst_sclk = bus.SCLK;
                fr_rst_mosi = bus.MOSI;
                fr_rst_busy = bus.busy;
                fr_rst_rx   = bus.rx_data;
            end
            if (rst_cyc != 0 && c == rst_cyc + 3) rst_n = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.SS, bus.SCLK, bus.MOSI} !== 3'b100) begin
            errors++;
            $display("FAIL reset_pins: SS,SCLK,MOSI=%b, required 100", {bus.SS, bus.SCLK, bus.MOSI});
        end
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_status: done,busy=%b, required 00", {bus.done, bus.busy});
        end
        checks++;
        if (bus.rx_data !== '0) begin
            errors++;
            $display("FAIL reset_rx_data: got %h, required 00", bus.rx_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        run_frame(8'hA5, 8'hA5, 0, 0, 0, 1'b1);
        checks++;
        if (fr_ss1 !== 1'b0 || fr_mosi1 !== 1'b1) begin
            errors++;
            $display("FAIL lb_cycle1: SS=%b MOSI=%b, required SS=0 MOSI=1", fr_ss1, fr_mosi1);
        end
        checks++;
        if (fr_rises != DW) begin
            errors++;
            $display("FAIL lb_rises: got %0d, required %0d", fr_rises, DW);
        end
        checks++;
        if (fr_mosi !== 8'hA5) begin
            errors++;
            $display("FAIL lb_mosi_bits: got %h, required a5", fr_mosi);
        end
        checks++;
        if (fr_done_n != 1 || fr_done_cyc != DONE_CYC) begin
            errors++;
            $display("FAIL lb_done: count %0d at cycle %0d, required 1 at %0d", fr_done_n, fr_done_cyc, DONE_CYC);
        end
        checks++;
        if (bus.rx_data !== 8'hA5) begin
            errors++;
            $display("FAIL lb_rx_data: got %h, required a5", bus.rx_data);
        end
    endtask

    task automatic test_miso_tied();
        logic [DW-1:0] exp_v;
        for (int m = 1; m <= 2; m++) begin
            exp_v = (m == 1) ? 8'h00 : 8'hFF;
            run_frame(8'h3C, exp_v, m, 0, 0, 1'b1);
            checks++;
            if (bus.rx_data !== exp_v) begin
                errors++;
                $display("FAIL tied_rx_data: mode %0d got %h, required %h", m, bus.rx_data, exp_v);
            end
            checks++;
            if (fr_busy_lo != 1 || fr_busy_hi != BUSY_END || fr_busy_n != BUSY_END) begin
                errors++;
                $display("FAIL tied_busy: high %0d..%0d (%0d cycles), required 1..%0d", fr_busy_lo, fr_busy_hi, fr_busy_n, BUSY_END);
            end
            checks++;
            if (fr_done_cyc != DONE_CYC) begin
                errors++;
                $display("FAIL tied_done_cyc: got %0d, required %0d", fr_done_cyc, DONE_CYC);
            end
        end
    endtask

    task automatic test_slave();
        sl_preload = 8'hFE;
        run_frame(8'h3C, 8'hFE, 3, 0, 0, 1'b1);
        checks++;
        if (bus.rx_data !== 8'hFE) begin
            errors++;
            $display("FAIL slave_master_rx: got %h, required fe", bus.rx_data);
        end
        checks++;
        if (sl_leds !== 8'h3C) begin
            errors++;
            $display("FAIL slave_leds: got %h, required 3c", sl_leds);
        end
    endtask

    task automatic test_start_ignored();
        run_frame(8'h5A, 8'h5A, 0, 20, 0, 1'b1);
        checks++;
        if (fr_done_n != 1) begin
            errors++;
            $display("FAIL busy_start_done_count: got %0d, required 1", fr_done_n);
        end
        checks++;
        if (fr_rises != DW) begin
            errors++;
            $display("FAIL busy_start_rises: got %0d, required %0d", fr_rises, DW);
        end
        checks++;
        if (fr_busy_n != BUSY_END) begin
            errors++;
            $display("FAIL busy_start_busy_len: got %0d, required %0d", fr_busy_n, BUSY_END);
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(8'hFF, 8'hFF, 0, 0, 30, 1'b0);
        checks++;
        if ({fr_rst_ss, fr_rst_sclk, fr_rst_mosi} !== 3'b100) begin
            errors++;
            $display("FAIL abort_pins: SS,SCLK,MOSI=%b, required 100", {fr_rst_ss, fr_rst_sclk, fr_rst_mosi});
        end
        checks++;
        if (fr_rst_busy !== 1'b0 || fr_rst_rx !== '0) begin
            errors++;
            $display("FAIL abort_status: busy=%b rx_data=%h, required 0 and 00", fr_rst_busy, fr_rst_rx);
        end
        checks++;
        if (fr_done_n != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses, required 0", fr_done_n);
        end
        run_frame(8'hC3, 8'hC3, 0, 0, 0, 1'b1);
        checks++;
        if (bus.rx_data !== 8'hC3 || fr_done_cyc != DONE_CYC || fr_rises != DW) begin
            errors++;
            $display("FAIL abort_recover: rx %h done@%0d rises %0d, required c3 done@%0d rises %0d", bus.rx_data, fr_done_cyc, fr_rises, DONE_CYC, DW);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals[3];
        logic [DW-1:0] got[3];
        int idx, dones, gaps, ss_run;
        bit seen_low;
        vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'hFF;
        got[0] = '0; got[1] = '0; got[2] = '0;
        idx = 1; dones = 0; gaps = 0; ss_run = 0; seen_low = 1'b0;
        miso_mode = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = vals[0];
        sb.push_back(vals[0]);
        for (int c = 1; c <= 400 && dones < 3; c++) begin
            @(negedge clk);
            if (bus.SS === 1'b1) begin
                ss_run++;
            end else begin
                if (seen_low && ss_run > 0) begin
                    gaps++;
                    checks++;
                    if (ss_run < CD) begin
                        errors++;
                        $display("FAIL b2b_ss_gap: SS high %0d cycles, required >= %0d", ss_run, CD);
                    end
                end
                seen_low = 1'b1;
                ss_run   = 0;
            end
            if (bus.done === 1'b1) begin
                got[dones] = bus.rx_data;
                dones++;
                if (idx < 3) begin
                    bus.tx_data = vals[idx];
                    sb.push_back(vals[idx]);
                    idx++;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (dones != 3) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d within budget, required 3", dones);
        end
        checks++;
        if (gaps != 2) begin
            errors++;
            $display("FAIL b2b_gap_count: got %0d, required 2", gaps);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== vals[i]) begin
                errors++;
                $display("FAIL b2b_rx_%0d: got %h, required %h", i, got[i], vals[i]);
            end
        end
        repeat (2 * CD + 2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
        sl_preload  = '0;
        sl_tx       = '0;
        sl_rx       = '0;
        sl_leds     = '0;
        test_reset();
        test_loopback();
        test_miso_tied();
        test_slave();
        test_start_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected frames never completed", sb.size());
        end
        checks++;
        if (done_total != 9) begin
            errors++;
            $display("FAIL done_total: got %0d pulses, required 9", done_total);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
